c3lib_ckmon: RTL and testbench
==============================

C3LIB_CKMON -- requirements
Module: c3lib_ckmon

Interface
REQ-001 SHALL have parameter WIN_W, default 16, sets the width of the window counter.
REQ-002 SHALL have parameter CNT_W, default 8, sets the width of the edge counter.
REQ-003 SHALL have port clk, input, 1 bit: the single reference clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mon_in, input, 1 bit: monitored clock (clock-buffer output), asynchronous to clk, sampled as data.
REQ-006 SHALL have port mon_en, input, 1 bit: enables measurement.
REQ-007 SHALL have port cfg_win_len, input, WIN_W bits: window length in clk cycles; 0 is treated as 1.
REQ-008 SHALL have port cfg_min_edges, input, CNT_W bits: lowest edge count that is not slow.
REQ-009 SHALL have port cfg_max_edges, input, CNT_W bits: highest edge count that is not fast.
REQ-010 SHALL have port edge_cnt, output, CNT_W bits: rising-edge count of the last completed window.
REQ-011 SHALL have port meas_done, output, 1 bit: one-cycle pulse when edge_cnt and the flags update.
REQ-012 SHALL have port ck_alive, output, 1 bit: last window had at least one edge.
REQ-013 SHALL have port ck_slow, output, 1 bit: edge_cnt is below cfg_min_edges.
REQ-014 SHALL have port ck_fast, output, 1 bit: edge_cnt is above cfg_max_edges.

Function
REQ-015 mon_in SHALL pass through the 2-flop synchronizer, then one history flop; a rising edge is detected when the synchronized value is 1 and the history value is 0.
REQ-016 The state machine SHALL have states IDLE, COUNT and EVAL.
REQ-017 IDLE SHALL go to COUNT when mon_en=1; on entry the window and edge counters load 0.
REQ-018 COUNT SHALL increment the window counter every cycle.
REQ-019 COUNT SHALL increment the edge counter on each detected edge.
REQ-020 The edge counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 COUNT SHALL go to EVAL in the cycle the window counter reaches max(cfg_win_len,1)-1; an edge detected in that cycle is counted.
REQ-022 EVAL SHALL last one cycle.
REQ-023 In EVAL the edge count SHALL be registered to edge_cnt.
REQ-024 In EVAL the flags SHALL be registered from that count.
REQ-025 meas_done SHALL be 1 in the cycle after EVAL.
REQ-026 After EVAL the state machine SHALL go to COUNT if mon_en=1, else to IDLE.
REQ-027 Latency: meas_done SHALL assert cfg_win_len+2 cycles after the cycle that enters COUNT.
REQ-028 mon_en deasserting in COUNT SHALL abort to IDLE next cycle; no meas_done and outputs hold.
REQ-029 cfg_* SHALL be sampled at COUNT entry and held for the window; mid-window changes take effect next window.
REQ-030 If cfg_min_edges > cfg_max_edges, both ck_slow and ck_fast MAY assert; no arbitration.

Reset
REQ-031 On rst_n=0, state SHALL be IDLE.
REQ-032 On rst_n=0, the synchronizer, history flop and counters SHALL be 0.
REQ-033 On rst_n=0, edge_cnt, meas_done, ck_alive, ck_slow and ck_fast SHALL be 0.
REQ-034 Reset asserted mid-window SHALL discard the partial count.
REQ-035 After reset release, the first edge detection SHALL be suppressed until the history flop has been loaded for one cycle.

Configuration
REQ-036 With macro C3LIB_CKMON_STICKY_EN defined, an extra input err_clr (1 bit) and output ck_err_sticky (1 bit) SHALL exist.
REQ-037 With C3LIB_CKMON_STICKY_EN defined, ck_err_sticky SHALL set at meas_done when ck_slow or ck_fast or !ck_alive, and hold until err_clr=1; set wins over a simultaneous clear.
REQ-038 Without C3LIB_CKMON_STICKY_EN, neither the err_clr nor the ck_err_sticky port nor its logic SHALL exist.

Structure
REQ-039 Package c3lib_ckmon_pkg SHALL hold the state enum (IDLE, COUNT, EVAL) and default WIN_W/CNT_W constants.
REQ-040 The synchronizer SHALL be sub-module c3lib_bitsync (2 flops, async active-low reset to 0).

Verification
REQ-041 mon_in period 8 clk, cfg_win_len=64, min=6, max=10 -> edge_cnt=8, ck_alive=1, slow=0, fast=0, meas_done at cycle 66.
REQ-042 mon_in stuck 0, cfg_win_len=32 -> edge_cnt=0, ck_alive=0, ck_slow=1 (min=1).
REQ-043 mon_in period 2 clk, cfg_win_len=1024, CNT_W=8 -> edge_cnt=255 (saturated), ck_fast=1 (max=200).
REQ-044 mon_en dropped at window cycle 20 of 64 -> no meas_done, prior outputs unchanged, IDLE.
REQ-045 rst_n pulsed low mid-window -> all outputs 0 immediately; first meas_done cfg_win_len+2 cycles after COUNT re-entry.
REQ-046 STICKY_EN build: slow window sets ck_err_sticky; err_clr with a concurrent failing meas_done leaves it 1; a later lone err_clr clears it.

Source files
------------

// File: rtl/c3lib_ckmon_pkg.sv
// Shared types and default widths for the c3lib_ckmon clock monitor.
package c3lib_ckmon_pkg;

    localparam int WIN_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EVAL  = 2'd2
    } state_t;

endpackage

// File: rtl/c3lib_bitsync.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 0.
module c3lib_bitsync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], d};
        end
    end

    assign q = sync[1];

endmodule

// File: rtl/c3lib_ckmon.sv
// Clock monitor: counts rising edges of mon_in over a window of clk cycles and flags dead/slow/fast.
// Optional sticky error flag with err_clr when C3LIB_CKMON_STICKY_EN is defined.
module c3lib_ckmon
    import c3lib_ckmon_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_in,
    input  logic             mon_en,
    input  logic [WIN_W-1:0] cfg_win_len,
    input  logic [CNT_W-1:0] cfg_min_edges,
    input  logic [CNT_W-1:0] cfg_max_edges,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             meas_done,
    output logic             ck_alive,
    output logic             ck_slow,
    output logic             ck_fast
`ifdef C3LIB_CKMON_STICKY_EN
    ,
    input  logic             err_clr,
    output logic             ck_err_sticky
`endif
);

    state_t           state;
    logic             mon_sync;
    logic             mon_hist;
    logic             hist_vld;
    logic             rise;
    logic             enter_count;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_last;
    logic [CNT_W-1:0] ecnt;
    logic [CNT_W-1:0] ecnt_nxt;
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;

    c3lib_bitsync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mon_in),
        .q     (mon_sync)
    );

    // hist_vld masks the first cycle after reset, before mon_hist holds a real sample.
    assign rise        = hist_vld & mon_sync & ~mon_hist;
    assign ecnt_nxt    = (rise && (ecnt != '1)) ? ecnt + CNT_W'(1) : ecnt;
    assign enter_count = mon_en && ((state == IDLE) || (state == EVAL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mon_hist  <= 1'b0;
            hist_vld  <= 1'b0;
            win_cnt   <= '0;
            win_last  <= '0;
            ecnt      <= '0;
            min_q     <= '0;
            max_q     <= '0;
            edge_cnt  <= '0;
            meas_done <= 1'b0;
            ck_alive  <= 1'b0;
            ck_slow   <= 1'b0;
            ck_fast   <= 1'b0;
        end else begin
            mon_hist  <= mon_sync;
            hist_vld  <= 1'b1;
            meas_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mon_en) state <= COUNT;
                end
                COUNT: begin
                    if (!mon_en) begin
                        state <= IDLE;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                        ecnt    <= ecnt_nxt;
                        if (win_cnt == win_last) state <= EVAL;
                    end
                end
                EVAL: begin
                    edge_cnt  <= ecnt;
                    ck_alive  <= (ecnt != '0);
                    ck_slow   <= (ecnt < min_q);
                    ck_fast   <= (ecnt > max_q);
                    meas_done <= 1'b1;
                    state     <= mon_en ? COUNT : IDLE;
                end
                default: state <= IDLE;
            endcase
            // Configuration is captured once per window so mid-window changes wait for the next one.
            if (enter_count) begin
                win_cnt  <= '0;
                ecnt     <= '0;
                win_last <= (cfg_win_len == '0) ? '0 : cfg_win_len - WIN_W'(1);
                min_q    <= cfg_min_edges;
                max_q    <= cfg_max_edges;
            end
        end
    end

`ifdef C3LIB_CKMON_STICKY_EN
    // A failing measurement takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck_err_sticky <= 1'b0;
        end else if (meas_done && (ck_slow || ck_fast || !ck_alive)) begin
            ck_err_sticky <= 1'b1;
        end else if (err_clr) begin
            ck_err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_c3lib_ckmon.sv
// Scoreboard bench for c3lib_ckmon: directed windows push expected results, a monitor pops on meas_done.
module tb_c3lib_ckmon;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mon_in;
    logic        mon_en;
    logic [15:0] cfg_win_len;
    logic [7:0]  cfg_min_edges;
    logic [7:0]  cfg_max_edges;
    logic [7:0]  edge_cnt;
    logic        meas_done;
    logic        ck_alive;
    logic        ck_slow;
    logic        ck_fast;
`ifdef C3LIB_CKMON_STICKY_EN
    logic        err_clr;
    logic        ck_err_sticky;
`endif

    c3lib_ckmon #(.WIN_W(16), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mon_in        (mon_in),
        .mon_en        (mon_en),
        .cfg_win_len   (cfg_win_len),
        .cfg_min_edges (cfg_min_edges),
        .cfg_max_edges (cfg_max_edges),
        .edge_cnt      (edge_cnt),
        .meas_done     (meas_done),
        .ck_alive      (ck_alive),
        .ck_slow       (ck_slow),
        .ck_fast       (ck_fast)
`ifdef C3LIB_CKMON_STICKY_EN
        ,
        .err_clr       (err_clr),
        .ck_err_sticky (ck_err_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cnt;
        logic       alive;
        logic       slow;
        logic       fast;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   period = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitored clock, generated synchronously with a configurable period (0 = stuck low).
    initial begin
        int ph;
        ph = 0;
        mon_in = 1'b0;
        forever begin
            @(negedge clk);
            if (period == 0) begin
                mon_in = 1'b0;
                ph = 0;
            end else begin
                ph = (ph + 1) % period;
                mon_in = (ph < period / 2);
            end
        end
    end

    // Monitor: each meas_done cycle consumes one expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (meas_done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_meas_done", 32'(meas_done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("edge_cnt", 32'(edge_cnt), 32'(mon_e.cnt));
                    check("ck_alive", 32'(ck_alive), 32'(mon_e.alive));
                    check("ck_slow", 32'(ck_slow), 32'(mon_e.slow));
                    check("ck_fast", 32'(ck_fast), 32'(mon_e.fast));
                    check("latency", 32'(cyc), 32'(mon_e.due));
                end
            end
        end
    end

    task automatic set_clr(input bit v);
`ifdef C3LIB_CKMON_STICKY_EN
        err_clr = v;
`endif
    endtask

    // One full window; chg_at > 0 changes the configuration mid-window at that cycle.
    task automatic run_window(input int len, input int minv, input int maxv, input int per,
                              input int e_cnt, input bit e_alive, input bit e_slow, input bit e_fast,
                              input int chg_at, input bit clr_at_done);
        int eff;
        eff = (len == 0) ? 1 : len;
        period = per;
        repeat (12) @(negedge clk);
        cfg_win_len   = 16'(len);
        cfg_min_edges = 8'(minv);
        cfg_max_edges = 8'(maxv);
        mon_en        = 1'b1;
        sb.push_back('{cnt: 8'(e_cnt), alive: e_alive, slow: e_slow, fast: e_fast, due: cyc + eff + 2});
        for (int k = 1; k <= eff + 1; k++) begin
            @(negedge clk);
            if (k == chg_at) begin
                cfg_win_len   = 16'd5;
                cfg_min_edges = 8'd0;
            end
        end
        mon_en = 1'b0;
        @(negedge clk);
        set_clr(clr_at_done);
        @(negedge clk);
        set_clr(1'b0);
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_outs(input string tag, input int e_cnt, input bit e_alive,
                              input bit e_slow, input bit e_fast, input bit e_done);
        check({tag, "_edge_cnt"}, 32'(edge_cnt), 32'(e_cnt));
        check({tag, "_alive"}, 32'(ck_alive), 32'(e_alive));
        check({tag, "_slow"}, 32'(ck_slow), 32'(e_slow));
        check({tag, "_fast"}, 32'(ck_fast), 32'(e_fast));
        check({tag, "_meas_done"}, 32'(meas_done), 32'(e_done));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        mon_en = 1'b0;
        cfg_win_len = '0;
        cfg_min_edges = '0;
        cfg_max_edges = '0;
        set_clr(1'b0);
        repeat (3) @(negedge clk);
        check_outs("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Nominal: period 8, window 64 -> 8 edges, in range.
        run_window(64, 6, 10, 8, 8, 1, 0, 0, 0, 0);

        // Abort at window cycle 20: no meas_done, outputs hold.
        period = 8;
        repeat (12) @(negedge clk);
        cfg_win_len = 16'd64;
        mon_en = 1'b1;
        repeat (21) @(negedge clk);
        mon_en = 1'b0;
        repeat (80) @(negedge clk);
        check_outs("abort_hold", 8, 1, 0, 0, 0);

        // Stuck low -> dead and slow; then saturation with fast flag.
        run_window(32, 1, 10, 0, 0, 0, 1, 0, 0, 0);
        run_window(1024, 6, 200, 2, 255, 1, 0, 1, 0, 0);

        // Reset mid-window clears everything at once.
        period = 8;
        repeat (12) @(negedge clk);
        cfg_win_len = 16'd64;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outs("midrst", 0, 0, 0, 0, 0);
`ifdef C3LIB_CKMON_STICKY_EN
        check("midrst_sticky", 32'(ck_err_sticky), 32'd0);
`endif
        @(negedge clk);
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Slow window after reset: 4 edges against min 6.
        run_window(32, 6, 10, 8, 4, 1, 1, 0, 0, 0);
`ifdef C3LIB_CKMON_STICKY_EN
        check("sticky_set", 32'(ck_err_sticky), 32'd1);
        run_window(32, 6, 10, 8, 4, 1, 1, 0, 0, 1);
        check("sticky_set_wins", 32'(ck_err_sticky), 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("sticky_clr", 32'(ck_err_sticky), 32'd0);
`endif

        // Zero window length behaves as 1; exact-threshold and inverted thresholds.
        run_window(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_window(64, 8, 8, 8, 8, 1, 0, 0, 0, 0);
        run_window(64, 9, 7, 8, 8, 1, 1, 1, 0, 0);

        // Mid-window config change is ignored until the next window.
        run_window(32, 6, 10, 8, 4, 1, 1, 0, 10, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
